// File: rtl/agm_core_mc.sv
// agm_core_mc -- multi-cycle AGM-V processor core.
//
// Fuses control FSM, PC, instruction register, register file and ALU behind
// one req/ack memory port, so memories with any number of wait states work.
// Each instruction is three sequential words (opcode, op1, op2). Fetch is
// followed by an execute cycle and, for LD/ST, one memory phase.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   mem_req    access request, held until mem_ack
//   mem_we     1 = write, 0 = read (valid while mem_req)
//   mem_addr   access address (stable while mem_req)
//   mem_wdata  write data (stable while mem_req && mem_we)
//   mem_rdata  read data, sampled on the edge where mem_ack = 1
//   mem_ack    access complete, may rise in the same cycle as mem_req
//   halted     core stopped (HALT or illegal opcode)
//   illegal_op sticky illegal-opcode indicator
//   flag_z     zero flag
//   flag_c     carry / borrow flag
//   dbg_pc     current PC
//   dbg_ir     last completely fetched instruction {opcode, op1, op2}
//   dbg_sel    debug register select
//   dbg_rdata  R[dbg_sel], combinational
//
// NREG must be a power of two and at least 2.

module agm_core_mc #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int NREG     = 4,
    parameter int RESET_PC = 0,
    localparam int SEL_W   = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int IR_W    = 8 + 2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              illegal_op,
    output logic              flag_z,
    output logic              flag_c,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [IR_W-1:0]   dbg_ir,
    input  logic [SEL_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h02;
    localparam logic [7:0] OP_SUB  = 8'h03;
    localparam logic [7:0] OP_AND  = 8'h04;
    localparam logic [7:0] OP_OR   = 8'h05;
    localparam logic [7:0] OP_XOR  = 8'h06;
    localparam logic [7:0] OP_CMP  = 8'h07;
    localparam logic [7:0] OP_LD   = 8'h08;
    localparam logic [7:0] OP_ST   = 8'h09;
    localparam logic [7:0] OP_JMP  = 8'h0A;
    localparam logic [7:0] OP_JZ   = 8'h0B;
    localparam logic [7:0] OP_JC   = 8'h0C;
    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef enum logic [2:0] {
        S_F0   = 3'd0,
        S_F1   = 3'd1,
        S_F2   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [7:0]          op_q;
    logic [DATA_W-1:0]   op1_q;
    logic [IR_W-1:0]     ir_q;
    logic                z_q;
    logic                c_q;
    logic                ill_q;
    logic [DATA_W-1:0]   regs_q [NREG];

    // Instruction fields, always taken from the committed IR.
    logic [7:0]          ir_op;
    logic [DATA_W-1:0]   ir_a;
    logic [DATA_W-1:0]   ir_b;
    logic [SEL_W-1:0]    rd;
    logic [SEL_W-1:0]    rs;
    logic [ADDR_W-1:0]   adr;
    logic [7:0]          op_in;
    logic [ADDR_W-1:0]   pc_inc;

    assign ir_op  = ir_q[IR_W-1 -: 8];
    assign ir_a   = ir_q[2*DATA_W-1 -: DATA_W];
    assign ir_b   = ir_q[DATA_W-1:0];
    assign rd     = ir_a[SEL_W-1:0];
    assign rs     = ir_b[SEL_W-1:0];
    assign pc_inc = pc_q + ADDR_W'(1);

    // Only the register-select bits of op1 matter.
    logic unused_ir_a;
    assign unused_ir_a = ^ir_a;

    // op2 is resized to an address; the opcode word is resized to 8 bits.
    generate
        if (ADDR_W <= DATA_W) begin : g_adr_trunc
            assign adr = ir_b[ADDR_W-1:0];
        end else begin : g_adr_ext
            assign adr = {{(ADDR_W-DATA_W){1'b0}}, ir_b};
        end
        if (DATA_W >= 8) begin : g_op_trunc
            assign op_in = mem_rdata[7:0];
        end else begin : g_op_ext
            assign op_in = {{(8-DATA_W){1'b0}}, mem_rdata};
        end
    endgenerate

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
    logic [DATA_W:0]   alu_sum;
    logic [DATA_W:0]   alu_diff;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_z;
    logic              alu_op;

    assign ra = regs_q[rd];
    assign rb = regs_q[rs];

    always_comb begin
        alu_sum  = {1'b0, ra} + {1'b0, rb};
        // The extra top bit of the difference is the unsigned borrow.
        alu_diff = {1'b0, ra} - {1'b0, rb};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_op   = 1'b0;
        case (ir_op)
            OP_ADD: begin
                alu_res = alu_sum[DATA_W-1:0];
                alu_c   = alu_sum[DATA_W];
                alu_op  = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                alu_res = alu_diff[DATA_W-1:0];
                alu_c   = alu_diff[DATA_W];
                alu_op  = 1'b1;
            end
            OP_AND: begin
                alu_res = ra & rb;
                alu_op  = 1'b1;
            end
            OP_OR: begin
                alu_res = ra | rb;
                alu_op  = 1'b1;
            end
            OP_XOR: begin
                alu_res = ra ^ rb;
                alu_op  = 1'b1;
            end
            default: begin
                alu_res = '0;
            end
        endcase
        alu_z = (alu_res == '0);
    end

    // ------------------------------------------------------------------
    // Register file write port: EX (LDI / ALU) or MEM (LD completion)
    // ------------------------------------------------------------------
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        if (state_q == S_EX) begin
            if (ir_op == OP_LDI) begin
                wr_en   = 1'b1;
                wr_data = ir_b;
            end else if (alu_op && ir_op != OP_CMP) begin
                wr_en   = 1'b1;
                wr_data = alu_res;
            end
        end else if (state_q == S_MEM && ir_op == OP_LD && mem_ack) begin
            wr_en   = 1'b1;
            wr_data = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rd] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM, PC, IR and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_F0;
            pc_q    <= ADDR_W'(RESET_PC);
            op_q    <= '0;
            op1_q   <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            case (state_q)
                S_F0: begin
                    if (mem_ack) begin
                        op_q    <= op_in;
                        pc_q    <= pc_inc;
                        state_q <= S_F1;
                    end
                end
                S_F1: begin
                    if (mem_ack) begin
                        op1_q   <= mem_rdata;
                        pc_q    <= pc_inc;
                        state_q <= S_F2;
                    end
                end
                S_F2: begin
                    // IR is committed as a whole so dbg_ir never shows a
                    // partially fetched instruction.
                    if (mem_ack) begin
                        ir_q    <= {op_q, op1_q, mem_rdata};
                        pc_q    <= pc_inc;
                        state_q <= S_EX;
                    end
                end
                S_EX: begin
                    state_q <= S_F0;
                    if (alu_op) begin
                        z_q <= alu_z;
                        c_q <= alu_c;
                    end
                    case (ir_op)
                        OP_NOP, OP_LDI, OP_ADD, OP_SUB,
                        OP_AND, OP_OR, OP_XOR, OP_CMP: begin
                            state_q <= S_F0;
                        end
                        OP_LD, OP_ST: state_q <= S_MEM;
                        OP_JMP:       pc_q <= adr;
                        OP_JZ:        if (z_q) pc_q <= adr;
                        OP_JC:        if (c_q) pc_q <= adr;
                        OP_HALT:      state_q <= S_HALT;
                        default: begin
                            ill_q   <= 1'b1;
                            state_q <= S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        state_q <= S_F0;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The request is masked while reset is asserted because the
    // reset state is F0, which would otherwise already be requesting.
    // ------------------------------------------------------------------
    logic in_access;
    assign in_access  = (state_q == S_F0) || (state_q == S_F1) ||
                        (state_q == S_F2) || (state_q == S_MEM);
    assign mem_req    = rst && in_access;
    assign mem_we     = rst && (state_q == S_MEM) && (ir_op == OP_ST);
    assign mem_addr   = (state_q == S_MEM) ? adr : pc_q;
    assign mem_wdata  = ra;
    assign halted     = (state_q == S_HALT);
    assign illegal_op = ill_q;
    assign flag_z     = z_q;
    assign flag_c     = c_q;
    assign dbg_pc     = pc_q;
    assign dbg_ir     = ir_q;
    assign dbg_rdata  = regs_q[dbg_sel];

endmodule

// File: doc/agm_core_mc.md
Name: agm_core_mc

Overview:
Parametrised multi-cycle processor core, the next generation of the 8-bit AGM-V processor top. It fuses the control unit, PC, instruction register, register file and ALU behind a single memory port with a req/ack handshake, so wait-state RAM is supported. Each instruction is 3 data words fetched sequentially (opcode, op1, op2), followed by execute and an optional memory phase. The core adds halt and illegal-opcode detection, Z/C flags with conditional jumps, and a debug read port.

Parameters:
DATA_W, 8, datapath, register and memory word width; also the op1/op2 field width (min 4)
ADDR_W, 8, PC and memory address width; op2 is zero-extended or truncated to ADDR_W
NREG, 4, number of general registers; power of 2, NREG <= 2^DATA_W
RESET_PC, 0, PC value loaded at reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
mem_req  out  1  memory access request; held until acked
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  ADDR_W  access address; stable while mem_req
mem_wdata  out  DATA_W  write data; stable while mem_req && mem_we
mem_rdata  in  DATA_W  read data; sampled on the edge where mem_ack=1
mem_ack  in  1  access complete; may go high in the same cycle mem_req rises
halted  out  1  core stopped (HALT executed or illegal opcode)
illegal_op  out  1  sticky; illegal opcode was decoded
flag_z  out  1  zero flag
flag_c  out  1  carry/borrow flag
dbg_pc  out  ADDR_W  current PC
dbg_ir  out  8+2*DATA_W  last fully fetched instruction {opcode, op1, op2}
dbg_sel  in  log2(NREG)  register select for debug read
dbg_rdata  out  DATA_W  R[dbg_sel], combinational

Behaviour:
- Reset (rst=0 at edge): PC=RESET_PC, all R=0, Z=C=0, IR=0, halted=0, illegal_op=0, state=F0, mem_req=0. Reset wins over everything, including mid-access; an unacked access is abandoned and never retried.
- States: F0, F1, F2, EX, MEM, HALT. mem_req=1 exactly in F0/F1/F2/MEM; outputs are decoded from registered state.
- F0/F1/F2: read at PC. On ack, capture opcode/op1/op2, PC<=PC+1 (mod 2^ADDR_W), advance to the next state. F2 goes to EX. No ack: hold state, address and req.
- rd = op1 mod NREG; rs = op2 mod NREG; adr = op2 resized to ADDR_W.
- EX, by opcode (next state F0 unless stated):
  - 00 NOP.
  - 01 LDI: R[rd]=op2.
  - 02 ADD: R[rd]=R[rd]+R[rs]; C=carry-out; Z=(result==0).
  - 03 SUB: R[rd]=R[rd]-R[rs]; C=borrow (R[rd]<R[rs] unsigned); Z as ADD.
  - 04 AND / 05 OR / 06 XOR: bitwise; Z updated; C cleared.
  - 07 CMP: flags as SUB; no register write.
  - 08 LD: go to MEM, read at adr; on ack R[rd]=mem_rdata.
  - 09 ST: go to MEM, write R[rd] to adr; done on ack.
  - 0A JMP: PC=adr. 0B JZ: PC=adr if Z. 0C JC: PC=adr if C.
  - FF HALT: go to HALT.
  - Any other opcode: illegal_op=1, go to HALT, no state change.
- Flags change only on 02–07. LDI/LD/ST/jumps leave flags untouched.
- HALT: absorbing until reset. halted=1, mem_req=0, PC holds the address after the halting instruction.
- Latency with zero-wait memory (ack in the same cycle as req): 4 cycles per instruction, 5 for LD/ST. Each wait cycle adds 1.
- Jump target fetched next F0. PC wraps silently from 2^ADDR_W-1 to 0, including mid-instruction.
- Registers written only in EX/MEM; dbg_rdata reflects a write the cycle after the writing edge.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random mem_ack -> mem_req=0, dbg_pc=0, all regs 0, flags 0, halted=0; first req at addr 0 on the cycle after rst rises.
- Program, zero-wait (DATA_W=8): mem[0..14]={01 00 05, 01 01 03, 02 00 01, 09 00 80, FF 00 00} -> write 0x08 to addr 0x80; halted=1 at cycle 21; dbg_pc=0x0F; R0=0x08, R1=0x03.
- Flags: LDI R0=F0, R1=20, ADD -> R0=0x10, C=1, Z=0. Then LDI R2=10, SUB R0,R2 -> Z=1, C=0. Then CMP R1,R0 (0x20 vs 0x10) -> C=0; CMP R0,R1 -> C=1. JZ 0x40 after SUB taken -> next fetch at 0x40; JC not taken when C=0.
- Wait states: mem_ack delayed 3 cycles on every access -> mem_req, addr and we stable throughout; LDI completes in 3*4+1=13 cycles; LD completes in 17 cycles.
- Illegal opcode 0x42 -> illegal_op=1, halted=1, registers and flags unchanged, no further mem_req.
- Reset mid-MEM of a ST, ack withheld -> after reset no write issued, PC=0, fetch restarts at 0.
- Wrap (ADDR_W=4): instruction at 0xE -> op2 fetched from 0x0; next PC=0x1.
